// File: rtl/regfile_pkg.sv
// Shared types for the register-bank host controller: command opcodes,
// controller FSM states and the bank-size helper.
package regfile_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CLEAR,
    ST_VERIFY,
    ST_RESP
  } state_t;

  function automatic int unsigned num_regs(input int unsigned n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/regfile_host_ctrl.sv
// Command-driven host controller for the 2^N x W register bank.
// Optional readback check of every WRITE is enabled by REGFILE_READBACK_VERIFY_EN.
module regfile_host_ctrl
  import regfile_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_addr_a,
  input  logic [N-1:0] cmd_addr_b,
  input  logic [W-1:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data_a,
  output logic [W-1:0] rsp_data_b,
  output logic         rsp_err,
  output logic         rf_we,
  output logic [N-1:0] rf_addr_rd,
  output logic [W-1:0] rf_data_in,
  output logic [N-1:0] rf_addr_rs1,
  output logic [N-1:0] rf_addr_rs2,
  input  logic [W-1:0] rf_rs1,
  input  logic [W-1:0] rf_rs2,
  output logic         busy
);

  localparam logic [N-1:0] LAST_PTR = N'(num_regs(N) - 1);

  state_t       state, state_next;
  op_t          op;
  logic         cmd_fire;
  logic [N-1:0] addr_a_q, addr_b_q, ptr_q;
  logic [W-1:0] data_q;
  logic [W-1:0] rsp_data_a_q, rsp_data_b_q;
  logic         addr_a_zero;

  assign op          = op_t'(cmd_op);
  assign cmd_ready   = (state == ST_IDLE) && !rst;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign addr_a_zero = (addr_a_q == '0);
  assign rsp_data_a  = rsp_data_a_q;
  assign rsp_data_b  = rsp_data_b_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_q   <= '0;
    end else if (cmd_fire) begin
      addr_a_q <= cmd_addr_a;
      addr_b_q <= cmd_addr_b;
      data_q   <= cmd_data;
    end
  end

  // Sweep pointer stops at the last register instead of wrapping to 0.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= '0;
    else if (cmd_fire && op == OP_CLEAR)
      ptr_q <= N'(1);
    else if (state == ST_CLEAR && ptr_q != LAST_PTR)
      ptr_q <= ptr_q + N'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_a_q <= '0;
      rsp_data_b_q <= '0;
    end else begin
      case (state)
        ST_READ: begin
          rsp_data_a_q <= rf_rs1;
          rsp_data_b_q <= rf_rs2;
        end
`ifdef REGFILE_READBACK_VERIFY_EN
        ST_WRITE: begin
          if (addr_a_zero) begin
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
          end
        end
        ST_VERIFY: begin
          rsp_data_a_q <= rf_rs1;
          rsp_data_b_q <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef REGFILE_READBACK_VERIFY_EN
  logic rsp_err_q;

  // A write to register 0 can never stick, so it is reported as an error.
  always_ff @(posedge clk) begin
    if (rst)
      rsp_err_q <= 1'b0;
    else if (state == ST_READ)
      rsp_err_q <= 1'b0;
    else if (state == ST_WRITE && addr_a_zero)
      rsp_err_q <= 1'b1;
    else if (state == ST_VERIFY)
      rsp_err_q <= (rf_rs1 != data_q);
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: next state defaults to the current state before the case so no
  // path through this block leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (op)
            OP_WRITE: state_next = ST_WRITE;
            OP_READ:  state_next = ST_READ;
            OP_CLEAR: state_next = ST_CLEAR;
            default:  state_next = ST_IDLE;
          endcase
        end
      end
`ifdef REGFILE_READBACK_VERIFY_EN
      ST_WRITE:  state_next = addr_a_zero ? ST_RESP : ST_VERIFY;
      ST_VERIFY: state_next = ST_RESP;
`else
      ST_WRITE:  state_next = ST_IDLE;
`endif
      ST_READ:   state_next = ST_RESP;
      ST_CLEAR:  if (ptr_q == LAST_PTR) state_next = ST_IDLE;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Bank pins decode only from registered state and latched fields; rst
  // masks them so the edge that aborts a sweep writes nothing.
  always_comb begin
    rf_we       = 1'b0;
    rf_addr_rd  = '0;
    rf_data_in  = '0;
    rf_addr_rs1 = '0;
    rf_addr_rs2 = '0;
    rsp_valid   = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_WRITE: begin
          rf_we      = !addr_a_zero;
          rf_addr_rd = addr_a_q;
          rf_data_in = data_q;
        end
        ST_READ: begin
          rf_addr_rs1 = addr_a_q;
          rf_addr_rs2 = addr_b_q;
        end
`ifdef REGFILE_READBACK_VERIFY_EN
        ST_VERIFY: rf_addr_rs1 = addr_a_q;
`endif
        ST_CLEAR: begin
          rf_we      = 1'b1;
          rf_addr_rd = ptr_q;
        end
        ST_RESP: rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_host_ctrl.sv
// Directed bench for regfile_host_ctrl with a behavioural 32 x 8 register bank
// attached; follows REGFILE_READBACK_VERIFY_EN when it is defined.
module tb_regfile_host_ctrl;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [4:0] cmd_addr_a = '0, cmd_addr_b = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data_a, rsp_data_b;
  logic       rsp_err;
  logic       rf_we;
  logic [4:0] rf_addr_rd, rf_addr_rs1, rf_addr_rs2;
  logic [7:0] rf_data_in, rf_rs1, rf_rs2;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [7:0] bank [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) begin
      bank[rf_addr_rd] <= rf_data_in;
      we_count <= we_count + 1;
    end
  end
  assign rf_rs1 = (rf_addr_rs1 == 5'd0) ? 8'h00 : bank[rf_addr_rs1];
  assign rf_rs2 = (rf_addr_rs2 == 5'd0) ? 8'h00 : bank[rf_addr_rs2];

  regfile_host_ctrl #(.N(5), .W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_err(rsp_err),
    .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_data_in(rf_data_in),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [7:0] d);
    int n = 0;
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
  endtask

  task automatic get_rsp(output logic [7:0] da, output logic [7:0] db, output logic err);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    da = rsp_data_a; db = rsp_data_b; err = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
`ifdef REGFILE_READBACK_VERIFY_EN
    logic [7:0] da, db;
    logic       err;
    logic       exp_err;
    logic [7:0] exp_da;
`endif
    send_cmd(OP_WRITE, a, 5'd0, d);
`ifdef REGFILE_READBACK_VERIFY_EN
    exp_err = (a == 5'd0);
    exp_da  = exp_err ? 8'h00 : d;
    get_rsp(da, db, err);
    checks++;
    if (err !== exp_err || da !== exp_da) begin
      errors++;
      $display("FAIL write_verify a=%0d: err=%b data_a=%h required err=%b data_a=%h",
               a, err, da, exp_err, exp_da);
    end
`endif
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                         output logic [7:0] da, output logic [7:0] db);
    logic err;
    send_cmd(OP_READ, a, b, 8'h00);
    get_rsp(da, db, err);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL read_err a=%0d: rsp_err=%b required 0", a, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err, rf_we, rf_addr_rd,
         rf_data_in, rf_addr_rs1, rf_addr_rs2, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b da=%h db=%h err=%b we=%b busy=%b required all 0",
               cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err, rf_we, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_read();
    int we0 = we_count;
    send_cmd(OP_WRITE, 5'd3, 5'd0, 8'hA5);
    checks++;
    if (rf_we !== 1'b1 || rf_addr_rd !== 5'd3 || rf_data_in !== 8'hA5 ||
        cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write_pins: we=%b addr=%0d data=%h ready=%b busy=%b required 1 3 a5 0 1",
               rf_we, rf_addr_rd, rf_data_in, cmd_ready, busy);
    end
`ifdef REGFILE_READBACK_VERIFY_EN
    begin
      logic [7:0] da, db;
      logic       err;
      get_rsp(da, db, err);
      checks++;
      if (err !== 1'b0 || da !== 8'hA5) begin
        errors++;
        $display("FAIL write_verify_a3: err=%b data_a=%h required 0 a5", err, da);
      end
    end
`endif
    send_cmd(OP_READ, 5'd3, 5'd0, 8'h00);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_latency_early: rsp_valid=%b required 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hA5 || rsp_data_b !== 8'h00) begin
      errors++;
      $display("FAIL read_a3: valid=%b da=%h db=%h required 1 a5 00",
               rsp_valid, rsp_data_a, rsp_data_b);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (we_count - we0 !== 1) begin
      errors++;
      $display("FAIL write_pulses: count=%0d required 1", we_count - we0);
    end
  endtask

  task automatic test_write_zero();
    int we0 = we_count;
    logic [7:0] da, db;
    do_write(5'd0, 8'hFF);
    do_read(5'd0, 5'd0, da, db);
    checks++;
    if (we_count !== we0 || da !== 8'h00 || db !== 8'h00) begin
      errors++;
      $display("FAIL write_zero: pulses=%0d da=%h db=%h required 0 00 00",
               we_count - we0, da, db);
    end
  endtask

  task automatic test_backpressure();
    do_write(5'd7, 8'h3C);
    send_cmd(OP_READ, 5'd3, 5'd7, 8'h00);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data_a !== 8'hA5 || rsp_data_b !== 8'h3C ||
          cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b da=%h db=%h ready=%b required 1 a5 3c 0",
                 i, rsp_valid, rsp_data_a, rsp_data_b, cmd_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: ready=%b valid=%b required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    logic [7:0] da, db;
    for (int i = 1; i < 32; i++) do_write(5'(i), 8'(i));
    send_cmd(OP_CLEAR, 5'd0, 5'd0, 8'h00);
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles !== 31) begin
      errors++;
      $display("FAIL clear_busy_cycles: got %0d required 31", busy_cycles);
    end
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), 5'(31 - i), da, db);
      checks++;
      if (da !== 8'h00 || db !== 8'h00) begin
        errors++;
        $display("FAIL clear_read a=%0d: da=%h db=%h required 00 00", i, da, db);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] da, db;
    logic [7:0] exp;
    for (int i = 1; i < 32; i++) do_write(5'(i), 8'(8'h40 + i));
    send_cmd(OP_CLEAR, 5'd0, 5'd0, 8'h00);
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (rf_we !== 1'b1 || rf_addr_rd !== 5'd10) begin
      errors++;
      $display("FAIL clear_ptr10: we=%b addr=%0d required 1 10", rf_we, rf_addr_rd);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, rsp_valid, rf_we, rf_addr_rd, rf_data_in, busy} !== '0) begin
      errors++;
      $display("FAIL mid_clear_reset: ready=%b valid=%b we=%b addr=%0d busy=%b required all 0",
               cmd_ready, rsp_valid, rf_we, rf_addr_rd, busy);
    end
    rst = 1'b0;
    tick();
    for (int i = 1; i < 32; i++) begin
      exp = (i < 10) ? 8'h00 : 8'(8'h40 + i);
      do_read(5'(i), 5'd0, da, db);
      checks++;
      if (da !== exp) begin
        errors++;
        $display("FAIL partial_clear a=%0d: got %h required %h", i, da, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_zero();
    test_backpressure();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
